// File: rtl/mcp300x_scan.sv
// Scanning SPI master for MCP3004/MCP3008 10-bit ADCs: masked channel sweep, SGL/DIFF select,
// power-of-two averaging and per-channel result strobes. SCLK is a registered output on CLK50.
module mcp300x_scan #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned CLK_DIV  = 13,
    parameter int unsigned AVG_LOG2 = 0,
    parameter bit          DIFF     = 1'b0
) (
    input  logic                     CLK50,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [CHANNELS-1:0]      chan_mask,
    input  logic                     SPI_IN,
    output logic                     SPI_OUT,
    output logic                     SCLK,
    output logic                     CS_n,
    output logic [CHANNELS-1:0][9:0] adc_out,
    output logic [CHANNELS-1:0]      adc_valid,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int unsigned CntW   = $clog2(2 * CLK_DIV);
    localparam int unsigned AccW   = 10 + AVG_LOG2;
    localparam int unsigned NsW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned NumAvg = 1 << AVG_LOG2;

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StStore} state_e;

    state_e                     state_q;
    logic [CntW-1:0]            cnt_q;
    logic [4:0]                 bit_q;
    logic [2:0]                 ch_q;
    logic [CHANNELS-1:0]        mask_q;
    logic [NsW-1:0]             nsamp_q;
    logic [AccW-1:0]            acc_q;
    logic [9:0]                 rx_q;
    logic [1:0]                 sync_q;
    logic                       sclk_q;
    logic                       cs_n_q;
    logic                       spi_out_q;
    logic [CHANNELS-1:0][9:0]   adc_out_q;
    logic [CHANNELS-1:0]        valid_q;
    logic                       frame_q;
    logic [23:0]                tx_w;
    logic [2:0]                 next_ch_w;

    // Lowest enabled channel at or after start, wrapping; start is returned if none is enabled.
    function automatic logic [2:0] find_chan(input logic [CHANNELS-1:0] mask,
                                             input logic [2:0] start);
        logic [2:0]  res;
        logic [2:0]  idx;
        logic        found;
        int unsigned c;
        res   = start;
        found = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            c   = (32'(start) + i) % CHANNELS;
            idx = 3'(c);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign tx_w      = {8'h01, ~DIFF, ch_q, 4'b0000, 8'h00};
    assign next_ch_w = (32'(ch_q) == CHANNELS - 1) ? 3'd0 : 3'(ch_q + 3'd1);

    always_ff @(posedge CLK50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            ch_q      <= '0;
            mask_q    <= '0;
            nsamp_q   <= '0;
            acc_q     <= '0;
            rx_q      <= '0;
            sync_q    <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            spi_out_q <= 1'b0;
            adc_out_q <= '0;
            valid_q   <= '0;
            frame_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], SPI_IN};
            valid_q <= '0;
            frame_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en && (|chan_mask)) begin
                        ch_q      <= find_chan(chan_mask, ch_q);
                        mask_q    <= chan_mask;
                        cs_n_q    <= 1'b0;
                        cnt_q     <= '0;
                        spi_out_q <= 1'b0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == CntW'(CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q == CntW'(CLK_DIV - 1)) begin
                        cnt_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[8:0], sync_q[1]};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 5'd23) begin
                                cs_n_q    <= 1'b1;
                                spi_out_q <= 1'b0;
                                state_q   <= StHold;
                            end else begin
                                bit_q     <= bit_q + 5'd1;
                                spi_out_q <= tx_w[5'd22 - bit_q];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (cnt_q == CntW'(2 * CLK_DIV - 1)) begin
                        cnt_q <= '0;
                        acc_q <= acc_q + AccW'(rx_q);
                        // An averaging burst stays on its channel regardless of en.
                        if (nsamp_q == NsW'(NumAvg - 1)) begin
                            state_q <= StStore;
                        end else begin
                            nsamp_q <= nsamp_q + 1'b1;
                            cs_n_q  <= 1'b0;
                            state_q <= StSetup;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStore: begin
                    adc_out_q[ch_q] <= 10'(acc_q >> AVG_LOG2);
                    valid_q[ch_q]   <= 1'b1;
                    frame_q         <= ~|((mask_q >> ch_q) >> 1);
                    acc_q           <= '0;
                    nsamp_q         <= '0;
                    ch_q            <= find_chan(chan_mask, next_ch_w);
                    if (en && (|chan_mask)) begin
                        mask_q  <= chan_mask;
                        cs_n_q  <= 1'b0;
                        state_q <= StSetup;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign SPI_OUT    = spi_out_q;
    assign SCLK       = sclk_q;
    assign CS_n       = cs_n_q;
    assign adc_out    = adc_out_q;
    assign adc_valid  = valid_q;
    assign frame_done = frame_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mcp300x_scan.sv
// Bench for mcp300x_scan: three configurations, each with an MCP300x model and a result
// scoreboard; directed sequences drive en/chan_mask/reset and check outputs.
module tb_mcp300x_scan;

    localparam int unsigned NumInst = 3;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n [NumInst];
    logic       en    [NumInst];
    logic [7:0] mask  [NumInst];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag, input logic cs_n_v, input logic sclk_v,
                                    input logic spi_v, input logic busy_v, input logic fd_v,
                                    input logic [7:0] valid_v, input logic [79:0] out_v);
        check_eq({tag, "_cs_n"}, cs_n_v, 1);
        check_eq({tag, "_sclk"}, sclk_v, 0);
        check_eq({tag, "_spi_out"}, spi_v, 0);
        check_eq({tag, "_busy"}, busy_v, 0);
        check_eq({tag, "_frame_done"}, fd_v, 0);
        check_eq({tag, "_adc_valid"}, valid_v, 0);
        check_eq({tag, "_adc_out_zero"}, (out_v == '0), 1);
    endtask

    function automatic int top_chan(input logic [7:0] m);
        int r;
        r = -1;
        for (int c = 0; c < 8; c++) if (m[c]) r = c;
        return r;
    endfunction

    function automatic logic [9:0] adc_value(input int g, input logic [2:0] ch, input int n);
        if (g == 0) return 10'h3A5 + 10'(ch);
        if (g == 1) begin
            case (n % 4)
                0:       return 10'd100;
                1:       return 10'd101;
                2:       return 10'd102;
                default: return 10'd104;
            endcase
        end
        return 10'h3FF;
    endfunction

    for (genvar g = 0; g < NumInst; g++) begin : g_inst
        localparam int unsigned Div  = (g == 0) ? 13 : ((g == 1) ? 5 : 4);
        localparam int unsigned Avg  = (g == 0) ? 0 : 2;
        localparam bit          Diff = (g == 2);

        logic            spi_in = 1'b0;
        logic            spi_out, sclk, cs_n, frame_done, busy;
        logic [7:0][9:0] adc_out;
        logic [7:0]      adc_valid;

        mcp300x_scan #(
            .CHANNELS (8),
            .CLK_DIV  (Div),
            .AVG_LOG2 (Avg),
            .DIFF     (Diff)
        ) u_dut (
            .CLK50      (clk),
            .reset_n    (rst_n[g]),
            .en         (en[g]),
            .chan_mask  (mask[g]),
            .SPI_IN     (spi_in),
            .SPI_OUT    (spi_out),
            .SCLK       (sclk),
            .CS_n       (cs_n),
            .adc_out    (adc_out),
            .adc_valid  (adc_valid),
            .frame_done (frame_done),
            .busy       (busy)
        );

        logic [23:0] cmd = '0;
        logic [23:0] cmd_last = '0;
        logic [9:0]  val = '0;
        int          idx = 0;
        int          n_conv = 0, burst_n = 0, sum = 0;
        int          n_cs_frames = 0, nvalid = 0, n_frame_done = 0;
        int          last_valid_cyc = 0, last_gap = 0, last_ch = 0;
        logic        prev_sclk = 1'b0, prev_cs = 1'b1;
        logic [12:0] exp_q[$];

        // ADC model and scoreboard, evaluated on the inactive clock edge.
        initial begin
            logic [12:0] e;
            int          vch;
            forever begin
                @(negedge clk);
                if (!rst_n[g]) begin
                    idx     = 0;
                    burst_n = 0;
                    sum     = 0;
                    spi_in  = 1'b0;
                    exp_q.delete();
                end else begin
                    if (adc_valid != '0) begin
                        vch = 0;
                        for (int c = 0; c < 8; c++) if (adc_valid[c]) vch = c;
                        nvalid++;
                        last_gap       = cyc - last_valid_cyc;
                        last_valid_cyc = cyc;
                        last_ch        = vch;
                        check_eq("valid_onehot", $countones(adc_valid), 1);
                        if (frame_done) n_frame_done++;
                        if (exp_q.size() == 0) begin
                            check_eq("unexpected_valid", adc_valid, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("valid_chan", vch, e[12:10]);
                            check_eq("adc_out_value", adc_out[vch], e[9:0]);
                            check_eq("frame_done_flag", frame_done, (vch == top_chan(mask[g])));
                        end
                    end else if (frame_done) begin
                        check_eq("stray_frame_done", frame_done, 0);
                    end
                    if (prev_cs && !cs_n) begin
                        idx    = 0;
                        cmd    = '0;
                        spi_in = 1'b1;
                    end
                    if (!prev_sclk && sclk && !cs_n) begin
                        cmd = {cmd[22:0], spi_out};
                        idx++;
                    end
                    if (prev_sclk && !sclk && !cs_n) begin
                        if (idx == 14) val = adc_value(g, cmd[4:2], n_conv);
                        if (idx < 13)      spi_in = 1'b1;
                        else if (idx < 14) spi_in = 1'b0;
                        else if (idx < 24) spi_in = val[23 - idx];
                        else               spi_in = 1'b0;
                    end
                    if (!prev_cs && cs_n) begin
                        spi_in = 1'b0;
                        if (idx == 24) begin
                            cmd_last = cmd;
                            n_cs_frames++;
                            check_eq("cmd_start", cmd[23:16], 8'h01);
                            check_eq("cmd_sgl", cmd[15], !Diff);
                            check_eq("cmd_tail", cmd[11:0], 0);
                            sum += int'(val);
                            burst_n++;
                            n_conv++;
                            if (burst_n == (1 << Avg)) begin
                                exp_q.push_back({cmd[14:12], 10'(sum >> Avg)});
                                sum     = 0;
                                burst_n = 0;
                            end
                        end
                    end
                end
                prev_sclk = sclk;
                prev_cs   = cs_n;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   t, nv, f0, fd0;
        logic seen;
        for (int g = 0; g < NumInst; g++) begin
            rst_n[g] = 1'b0;
            en[g]    = 1'b0;
            mask[g]  = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals("rst0", g_inst[0].cs_n, g_inst[0].sclk, g_inst[0].spi_out,
                         g_inst[0].busy, g_inst[0].frame_done, g_inst[0].adc_valid,
                         g_inst[0].adc_out);
        check_reset_vals("rst1", g_inst[1].cs_n, g_inst[1].sclk, g_inst[1].spi_out,
                         g_inst[1].busy, g_inst[1].frame_done, g_inst[1].adc_valid,
                         g_inst[1].adc_out);
        check_reset_vals("rst2", g_inst[2].cs_n, g_inst[2].sclk, g_inst[2].spi_out,
                         g_inst[2].busy, g_inst[2].frame_done, g_inst[2].adc_valid,
                         g_inst[2].adc_out);
        for (int g = 0; g < NumInst; g++) rst_n[g] = 1'b1;
        repeat (2) @(negedge clk);

        // en rising in IDLE, then reset asserted during SHIFT bit 12.
        mask[0] = 8'hFF;
        en[0]   = 1'b1;
        @(posedge clk);
        #1;
        check_eq("cs_n_after_en", g_inst[0].cs_n, 0);
        check_eq("busy_after_en", g_inst[0].busy, 1);
        t = 0;
        while (g_inst[0].idx != 12 && t < 3000) begin @(negedge clk); t++; end
        check_eq("wait_bit12", (t < 3000), 1);
        rst_n[0] = 1'b0;
        #1;
        check_reset_vals("rst_mid", g_inst[0].cs_n, g_inst[0].sclk, g_inst[0].spi_out,
                         g_inst[0].busy, g_inst[0].frame_done, g_inst[0].adc_valid,
                         g_inst[0].adc_out);
        en[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        nv = g_inst[0].nvalid;
        repeat (1500) @(negedge clk);
        check_eq("no_valid_after_abort", g_inst[0].nvalid, nv);
        check_eq("idle_after_abort", g_inst[0].busy, 0);

        // Mask 0b00100100: channels 2 and 5 alternate.
        mask[0] = 8'h24;
        en[0]   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nv = g_inst[0].nvalid;
            t  = 0;
            while (g_inst[0].nvalid == nv && t < 800) begin @(negedge clk); t++; end
            check_eq("wait_valid_mask24", (t < 800), 1);
            check_eq("mask24_chan", g_inst[0].last_ch, (i % 2 == 0) ? 2 : 5);
            check_eq("mask24_nibble", g_inst[0].cmd_last[15:12], (i % 2 == 0) ? 4'hA : 4'hD);
        end
        en[0] = 1'b0;
        t = 0;
        while (g_inst[0].busy && t < 1500) begin @(negedge clk); t++; end
        check_eq("mask24_idle", (t < 1500), 1);
        check_eq("adc_out0_held", g_inst[0].adc_out[0], 0);
        check_eq("adc_out1_held", g_inst[0].adc_out[1], 0);
        check_eq("adc_out2_value", g_inst[0].adc_out[2], 10'h3A7);

        // Mask 0 keeps the block idle even with en high.
        mask[0] = 8'h00;
        en[0]   = 1'b1;
        seen    = 1'b0;
        repeat (300) begin
            @(negedge clk);
            seen = seen | g_inst[0].busy | ~g_inst[0].cs_n;
        end
        check_eq("mask0_idle", seen, 0);
        en[0] = 1'b0;

        // Full sweep from a fresh pointer.
        rst_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        mask[0]  = 8'hFF;
        fd0      = g_inst[0].n_frame_done;
        en[0]    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nv = g_inst[0].nvalid;
            t  = 0;
            while (g_inst[0].nvalid == nv && t < 1500) begin @(negedge clk); t++; end
            check_eq("wait_valid_sweep", (t < 1500), 1);
            check_eq("sweep_chan", g_inst[0].last_ch, i);
            check_eq("sweep_nibble", g_inst[0].cmd_last[15:12], 8 + i);
            check_eq("sweep_adc_out", g_inst[0].adc_out[i], 10'h3A5 + 10'(i));
            if (i > 0) check_eq("sweep_gap", g_inst[0].last_gap, 664);
        end
        check_eq("sweep_frame_done_once", g_inst[0].n_frame_done - fd0, 1);
        en[0] = 1'b0;
        nv = g_inst[0].nvalid;
        t  = 0;
        while (g_inst[0].busy && t < 1500) begin @(negedge clk); t++; end
        check_eq("sweep_idle", (t < 1500), 1);
        check_eq("sweep_tail_valids", g_inst[0].nvalid - nv, 1);
        check_eq("sweep_frame_done_total", g_inst[0].n_frame_done - fd0, 1);

        // Averaging: four frames per result, then en dropped mid-burst.
        mask[1] = 8'h01;
        f0      = g_inst[1].n_cs_frames;
        en[1]   = 1'b1;
        t = 0;
        while (g_inst[1].nvalid == 0 && t < 1500) begin @(negedge clk); t++; end
        check_eq("wait_valid_avg", (t < 1500), 1);
        check_eq("avg_frames", g_inst[1].n_cs_frames - f0, 4);
        check_eq("avg_result", g_inst[1].adc_out[0], 10'd101);
        t = 0;
        while (!(g_inst[1].n_cs_frames == f0 + 5 && !g_inst[1].cs_n && g_inst[1].idx == 5)
               && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_eq("wait_avg_bit5", (t < 1000), 1);
        en[1] = 1'b0;
        nv = g_inst[1].nvalid;
        t  = 0;
        while (g_inst[1].busy && t < 1500) begin @(negedge clk); t++; end
        check_eq("avg_drop_idle", (t < 1500), 1);
        check_eq("avg_drop_valids", g_inst[1].nvalid - nv, 1);
        check_eq("avg_drop_frames", g_inst[1].n_cs_frames - f0, 8);
        check_eq("avg_drop_cs_n", g_inst[1].cs_n, 1);
        check_eq("avg_drop_sclk", g_inst[1].sclk, 0);
        check_eq("avg_drop_result", g_inst[1].adc_out[0], 10'd101);
        repeat (300) @(negedge clk);
        check_eq("avg_stays_idle", g_inst[1].busy, 0);

        // Differential mode on channel 3 with full-scale samples.
        mask[2] = 8'h08;
        en[2]   = 1'b1;
        t = 0;
        while (g_inst[2].nvalid == 0 && t < 1500) begin @(negedge clk); t++; end
        check_eq("wait_valid_diff", (t < 1500), 1);
        check_eq("diff_cmd_byte", g_inst[2].cmd_last[15:8], 8'h30);
        check_eq("diff_result", g_inst[2].adc_out[3], 10'h3FF);
        en[2] = 1'b0;
        t = 0;
        while (g_inst[2].busy && t < 1500) begin @(negedge clk); t++; end
        check_eq("diff_idle", (t < 1500), 1);
        check_eq("diff_result_final", g_inst[2].adc_out[3], 10'h3FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mcp300x_scan.md
# mcp300x_scan

Parametrised successor to the two-pot MCP3008 reader: a scanning SPI master for MCP3004/MCP3008 10-bit ADCs. It adds per-channel enable masking, single-ended or differential mode, optional power-of-two averaging, per-channel update strobes and a clean start/stop control. All logic runs on CLK50; SCLK is a registered output, never an internal clock. It sits between the ADC pins and the filter-parameter logic in the top level.

## Interface
- CHANNELS, default 8: number of ADC channels scanned, 1..8.
- CLK_DIV, default 13: SCLK half-period in CLK50 cycles, minimum 4 (13 gives 1.92 MHz).
- AVG_LOG2, default 0: each result averages 2^AVG_LOG2 consecutive conversions, 0..3.
- DIFF, default 0: 0 selects single-ended (SGL=1), 1 selects differential pair (SGL=0).
- CLK50 in 1: system clock; the only clock in the block.
- reset_n in 1: asynchronous, active-low reset.
- en in 1: level-sensitive; scanning runs while high.
- chan_mask in CHANNELS: bit c=1 includes channel c in the scan.
- SPI_IN in 1: ADC Dout.
- SPI_OUT out 1: ADC Din.
- SCLK out 1: SPI clock, mode 0 (idle low).
- CS_n out 1: ADC chip select.
- adc_out out CHANNELS x 10: latest result per channel.
- adc_valid out CHANNELS: one-cycle strobe, bit c high the cycle adc_out[c] updates.
- frame_done out 1: one-cycle strobe when the last enabled channel of a sweep is stored.
- busy out 1: high in every state except IDLE.

## Operation
- Reset values: SCLK=0, CS_n=1, SPI_OUT=0, adc_out=0, adc_valid=0, frame_done=0, busy=0, state IDLE, channel pointer 0, accumulator 0. An assertion mid-transfer aborts it immediately, with no completion strobe.
- States: IDLE, SETUP, SHIFT, HOLD, STORE.
- IDLE: wait for en=1 and chan_mask!=0. The pointer advances to the lowest enabled channel at or after the current pointer, wrapping. Then go to SETUP.
- SETUP: CS_n=0, SCLK=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 24 bits, MSB first. The tx word is {0x01, ~DIFF, ch[2:0], 4'b0, 0x00}.
  - Each bit: SCLK low for CLK_DIV cycles with SPI_OUT driving the bit, then SCLK high for CLK_DIV cycles.
  - SPI_IN passes through a 2-flop synchronizer and is shifted in on the CLK50 cycle SCLK rises.
- HOLD: after the 24th high phase, SCLK=0, SPI_OUT=0, CS_n=1 for 2*CLK_DIV cycles. Sample = last 10 received bits.
- Accumulate: acc += sample (acc width 10+AVG_LOG2). If fewer than 2^AVG_LOG2 samples are taken, go back to SETUP on the same channel. Otherwise go to STORE.
- STORE, one cycle:
  - adc_out[ch] = acc >> AVG_LOG2 (truncating), adc_valid[ch]=1, acc cleared.
  - frame_done=1 if ch is the highest enabled channel.
  - Pointer advances to the next enabled channel, wrapping.
  - If en=1 and the mask is non-zero, go to SETUP; otherwise go to IDLE.
- chan_mask is sampled only when a channel is selected. Changes apply from the next selection, and an averaging burst always finishes on its channel.
- en falling mid-conversion: the current conversion and its averaging burst complete and are stored, then the block goes to IDLE. CS_n is never cut short.
- Channels with mask bit 0 keep their last adc_out value.

## Timing
- One conversion = CLK_DIV + 48*CLK_DIV + 2*CLK_DIV = 51*CLK_DIV CLK50 cycles (663 at the default).
- One result = 2^AVG_LOG2 conversions + 1 STORE cycle. A full sweep = N_enabled results.
- SPI_OUT changes only while SCLK is low, at least CLK_DIV cycles before the rising edge.
- CS_n is high for at least 2*CLK_DIV cycles between conversions: 520 ns at the default, meeting tCSH.
- adc_valid and frame_done are never high for more than one consecutive cycle per event.
- From en rising in IDLE, CS_n falls on the next cycle.

## Test plan
- Reset during SHIFT at bit 12: all outputs return to reset values within the same cycle, and no adc_valid follows.
- CHANNELS=8, mask 0xFF, ADC model returns 0x3A5+c for channel c:
  - Din command nibbles are 0x8..0xF in order.
  - adc_out[c]=0x3A5+c.
  - frame_done occurs exactly once, with adc_valid[7].
  - Spacing between adc_valid strobes is 664 cycles.
- Mask 0b00100100: only channels 2 and 5 convert, alternating. adc_out[0] stays 0. Mask 0 holds the block in IDLE with busy=0.
- AVG_LOG2=2, model returns 100,101,102,104 on channel 0: four CS_n frames, then adc_out[0]=101 (407>>2).
- DIFF=1, channel 3: Din command byte is 0x30. Model returns 0x3FF: adc_out[3]=0x3FF, with no overflow in the accumulator.
- en dropped at bit 5 of conversion 2 of 4 (AVG_LOG2=2): the burst completes and one adc_valid is seen. The block then goes to IDLE, with CS_n high and SCLK low.
